// File: rtl/uart_block_assembler.sv
// -----------------------------------------------------------------------------
// uart_block_assembler
//
// Collects UART bytes into 128-bit ciphertext blocks for the first inverse
// round. Bytes fill an assembly register in arrival order (byte k lands in
// block_data[8k:8k+7]). Completed blocks move to an output register that
// holds them until the consumer accepts them with block_ready.
//
// When the output is still occupied, a finished block waits in the assembly
// register with byte_count=16 (pending). While a block is pending, any new
// byte is dropped and the sticky overflow flag is set. The exception is a
// byte that arrives in the same cycle the pending block moves to the output;
// that byte becomes slot 0 of the next block.
//
// Optional feature (macro ASM_TIMEOUT_EN): an idle counter discards a partial
// block (1..15 bytes) after TIMEOUT_CYCLES cycles without rx_valid. A pending
// block never times out. Without the macro, partial blocks are held
// indefinitely and no idle counter is built.
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         synchronous active-low reset
//   rx_byte       received byte
//   rx_valid      one-cycle strobe qualifying rx_byte
//   block_ready   consumer accepts block_data this cycle
//   overflow_clr  clears the overflow flag (a simultaneous drop wins)
//   block_data    assembled block, byte 0 in bits [0:7]
//   block_valid   block_data holds an unconsumed block
//   byte_count    bytes held in the assembly register (0..16)
//   overflow      sticky flag, set when a byte is dropped
// -----------------------------------------------------------------------------
module uart_block_assembler #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_byte,
    input  logic         rx_valid,
    input  logic         block_ready,
    input  logic         overflow_clr,
    output logic [0:127] block_data,
    output logic         block_valid,
    output logic [4:0]   byte_count,
    output logic         overflow
);

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t       state_q;
    logic [0:127] asm_q;
    logic [0:127] asm_d;
    logic [0:127] out_q;
    logic [4:0]   cnt_q;
    logic         ovf_q;

    logic handoff;
    logic pending;
    logic drop;
    logic timeout;

    assign handoff = (state_q == VALID) && block_ready;
    assign pending = (cnt_q == 5'd16);
    // A byte is lost only when the assembly register is full and is not
    // being freed this very cycle.
    assign drop    = rx_valid && pending && !handoff;

    // Assembly register with the incoming byte written into its slot.
    always_comb begin
        asm_d = asm_q;
        asm_d[{cnt_q[3:0], 3'b000} +: 8] = rx_byte;
    end

`ifdef ASM_TIMEOUT_EN
    logic [31:0] idle_q;

    // Fires on the cycle that would make the idle run TIMEOUT_CYCLES long.
    assign timeout = !rx_valid && (idle_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_q <= 32'd0;
        end else if (rx_valid) begin
            idle_q <= 32'd0;
        end else if (idle_q < 32'(TIMEOUT_CYCLES)) begin
            idle_q <= idle_q + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            asm_q   <= '0;
            out_q   <= '0;
            cnt_q   <= 5'd0;
            ovf_q   <= 1'b0;
        end else begin
            if (pending) begin
                if (handoff) begin
                    // Pending block replaces the one being consumed; output
                    // stays VALID. A byte arriving now starts the next block.
                    out_q <= asm_q;
                    if (rx_valid) begin
                        asm_q[0:7] <= rx_byte;
                        cnt_q      <= 5'd1;
                    end else begin
                        cnt_q <= 5'd0;
                    end
                end
            end else if (rx_valid) begin
                asm_q <= asm_d;
                if (cnt_q == 5'd15) begin
                    if (state_q == EMPTY || handoff) begin
                        out_q   <= asm_d;
                        state_q <= VALID;
                        cnt_q   <= 5'd0;
                    end else begin
                        cnt_q <= 5'd16;
                    end
                end else begin
                    cnt_q <= cnt_q + 5'd1;
                    if (handoff) begin
                        state_q <= EMPTY;
                    end
                end
            end else begin
                if (handoff) begin
                    state_q <= EMPTY;
                end
                if (timeout && cnt_q != 5'd0) begin
                    cnt_q <= 5'd0;
                end
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (overflow_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign block_data  = out_q;
    assign block_valid = (state_q == VALID);
    assign byte_count  = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_block_assembler.sv
// -----------------------------------------------------------------------------
// tb_uart_block_assembler
//
// Directed scenarios plus randomized traffic. A queue-based model of the
// block assembler is updated after every clock edge; a compare process checks
// all DUT outputs against it on every falling edge. Literal expectations in
// the directed scenarios pin the model itself.
// -----------------------------------------------------------------------------
module tb_uart_block_assembler;

    localparam int T_CYC = 50;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         block_ready;
    logic         overflow_clr;
    logic [0:127] block_data;
    logic         block_valid;
    logic [4:0]   byte_count;
    logic         overflow;

    uart_block_assembler #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .block_ready  (block_ready),
        .overflow_clr (overflow_clr),
        .block_data   (block_data),
        .block_valid  (block_valid),
        .byte_count   (byte_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // ---------------- behavioural model ----------------
    logic [7:0]   m_asm[$];
    logic [0:127] m_out;
    bit           m_valid;
    bit           m_ovf;
    int           m_idle;

    function automatic logic [0:127] pack_q(input logic [7:0] q[$]);
        logic [0:127] b;
        b = '0;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = q[k];
        return b;
    endfunction

    task automatic model_update(input bit v, input logic [7:0] b, input bit rdy,
                                input bit clr, input bit rst);
        bit hand;
        bit out_free;
        bit loaded;
        bit dropped;
        if (rst) begin
            m_asm.delete();
            m_out   = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_idle  = 0;
            return;
        end
        hand     = m_valid && rdy;
        out_free = !m_valid || hand;
        loaded   = 1'b0;
        dropped  = 1'b0;
        // A full block waiting for the output moves first, freeing room.
        if (m_asm.size() == 16 && out_free) begin
            m_out = pack_q(m_asm);
            m_asm.delete();
            loaded = 1'b1;
        end
        if (v) begin
            if (m_asm.size() < 16) m_asm.push_back(b);
            else dropped = 1'b1;
        end
        if (!loaded && m_asm.size() == 16 && out_free) begin
            m_out = pack_q(m_asm);
            m_asm.delete();
            loaded = 1'b1;
        end
        if (loaded) m_valid = 1'b1;
        else if (hand) m_valid = 1'b0;
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
`ifdef ASM_TIMEOUT_EN
        if (v) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == T_CYC && m_asm.size() > 0 && m_asm.size() < 16)
                m_asm.delete();
        end
`endif
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_block_valid", 128'(block_valid), 128'(m_valid));
            check("cyc_byte_count",  128'(byte_count),  128'(m_asm.size()));
            check("cyc_overflow",    128'(overflow),    128'(m_ovf));
            check("cyc_block_data",  block_data,        m_out);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input logic [7:0] b, input bit rdy,
                        input bit clr, input bit rst);
        rx_valid     = v;
        rx_byte      = b;
        block_ready  = rdy;
        overflow_clr = clr;
        rst_n        = !rst;
        @(posedge clk);
        model_update(v, b, rdy, clr, rst);
        @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, first + 8'(i), rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        rx_valid = 0; rx_byte = 0; block_ready = 0; overflow_clr = 0; rst_n = 0;
        m_out = '0; m_valid = 0; m_ovf = 0; m_idle = 0;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk_en = 1'b1;
        check("reset_valid", 128'(block_valid), 128'd0);
        check("reset_count", 128'(byte_count), 128'd0);
        check("reset_ovf",   128'(overflow), 128'd0);
        check("reset_data",  block_data, 128'h0);

        // Single block with consumer ready.
        send_bytes(8'h00, 16, 1'b1);
        check("blk0_valid", 128'(block_valid), 128'd1);
        check("blk0_data",  block_data, 128'h000102030405060708090A0B0C0D0E0F);
        check("blk0_count", 128'(byte_count), 128'd0);
        idle(1, 1'b1);
        check("blk0_consumed", 128'(block_valid), 128'd0);

        // Two blocks with consumer stalled: second one pends.
        send_bytes(8'h10, 16, 1'b0);
        send_bytes(8'h20, 16, 1'b0);
        check("pend_data_held", block_data, 128'h101112131415161718191A1B1C1D1E1F);
        check("pend_count", 128'(byte_count), 128'd16);
        idle(1, 1'b1);
        check("pend_xfer_valid", 128'(block_valid), 128'd1);
        check("pend_xfer_data",  block_data, 128'h202122232425262728292A2B2C2D2E2F);
        check("pend_xfer_count", 128'(byte_count), 128'd0);

        // Overflow on a byte arriving while pending.
        send_bytes(8'h30, 16, 1'b0);
        step(1, 8'hAA, 0, 0, 0);
        check("ovf_set",   128'(overflow), 128'd1);
        check("ovf_count", 128'(byte_count), 128'd16);
        step(0, 0, 0, 1, 0);
        check("ovf_clr", 128'(overflow), 128'd0);

        // Byte arriving on the same cycle the pending block is handed off.
        step(1, 8'hBB, 1, 0, 0);
        check("same_cyc_count", 128'(byte_count), 128'd1);
        check("same_cyc_ovf",   128'(overflow), 128'd0);
        check("same_cyc_data",  block_data, 128'h303132333435363738393A3B3C3D3E3F);
        send_bytes(8'hC1, 15, 1'b0);
        idle(1, 1'b1);
        check("same_cyc_slot0", 128'(block_data[0:7]), 128'hBB);
        idle(1, 1'b1);

        // Reset mid-block.
        send_bytes(8'h40, 7, 1'b0);
        step(1, 8'h99, 0, 0, 1);
        check("midrst_count", 128'(byte_count), 128'd0);
        check("midrst_valid", 128'(block_valid), 128'd0);
        send_bytes(8'h50, 16, 1'b1);
        check("midrst_clean", block_data, 128'h505152535455565758595A5B5C5D5E5F);
        idle(1, 1'b1);

        // Partial block timeout behaviour.
        send_bytes(8'h60, 5, 1'b0);
        idle(T_CYC - 1, 1'b0);
        check("to_before", 128'(byte_count), 128'd5);
        idle(1, 1'b0);
`ifdef ASM_TIMEOUT_EN
        check("to_after", 128'(byte_count), 128'd0);
`else
        check("to_after", 128'(byte_count), 128'd5);
`endif
        check("to_ovf", 128'(overflow), 128'd0);
        step(0, 0, 0, 0, 1);

        // A pending block never times out.
        send_bytes(8'h70, 16, 1'b0);
        send_bytes(8'h80, 16, 1'b0);
        idle(T_CYC + 10, 1'b0);
        check("pend_no_timeout", 128'(byte_count), 128'd16);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom),
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 999) < 4);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
